// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-memory and single-port memory signals around the arbiter.
// The slave view belongs to the arbiter; the master view belongs to the surrounding core and memory.
interface mem_port_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 if_req;
  logic [DataWidth-1:0] if_addr;
  logic                 if_valid;
  logic                 if_stall;
  logic [DataWidth-1:0] if_rdata;

  logic                 dm_req;
  logic                 dm_we;
  logic [3:0]           dm_mask;
  logic [DataWidth-1:0] dm_addr;
  logic [DataWidth-1:0] dm_wdata;
  logic                 dm_valid;
  logic                 dm_stall;
  logic [DataWidth-1:0] dm_rdata;

  logic                 mem_req;
  logic                 mem_we;
  logic [3:0]           mem_mask;
  logic [DataWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdata;
  logic                 mem_valid;
  logic [DataWidth-1:0] mem_rdata;

  logic                 err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, mem_valid, mem_rdata,
    output if_valid, if_stall, if_rdata, dm_valid, dm_stall, dm_rdata,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_mask, dm_addr, dm_wdata, mem_valid, mem_rdata,
    input  if_valid, if_stall, if_rdata, dm_valid, dm_stall, dm_rdata,
           mem_req, mem_we, mem_mask, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and data access,
// with a per-transaction busy timeout that completes the request with zero read data and an err pulse.
module mem_port_arbiter #(
  parameter int DataWidth = 32,
  parameter int Timeout   = 16
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [7:0] TmoLast = 8'(Timeout - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_d_q;  // 1: data port won the most recent grant
  logic [7:0]           cnt_q;
  logic [DataWidth-1:0] addr_q, wdata_q, if_rdata_q, dm_rdata_q;
  logic [3:0]           mask_q;
  logic                 we_q, if_valid_q, dm_valid_q, err_q;
  logic                 grant_i, grant_d, done, tmo, busy;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    done    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.if_req && (!bus.dm_req || last_d_q)) begin
          state_d = BUSY_I;
          grant_i = 1'b1;
        end else if (bus.dm_req) begin
          state_d = BUSY_D;
          grant_d = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        // A completion arriving in the final busy cycle beats the timeout.
        if (bus.mem_valid) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (cnt_q + 8'd1 == TmoLast) begin
          state_d = IDLE;
          tmo     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy          = (state_q != IDLE);
    bus.mem_req   = busy;
    bus.mem_we    = we_q;
    bus.mem_mask  = mask_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.if_valid  = if_valid_q;
    bus.dm_valid  = dm_valid_q;
    bus.if_rdata  = if_rdata_q;
    bus.dm_rdata  = dm_rdata_q;
    bus.err       = err_q;
    bus.if_stall  = bus.if_req & ~if_valid_q;
    bus.dm_stall  = bus.dm_req & ~dm_valid_q;
  end

  // Request capture, busy counter and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q   <= 1'b1;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_valid_q <= (state_q == BUSY_I) && (done || tmo);
      dm_valid_q <= (state_q == BUSY_D) && (done || tmo);
      err_q      <= tmo;

      if (grant_i || grant_d)        cnt_q <= '0;
      else if (busy && !bus.mem_valid) cnt_q <= cnt_q + 8'd1;

      if (grant_i) begin
        last_d_q <= 1'b0;
        addr_q   <= bus.if_addr;
        wdata_q  <= '0;
        mask_q   <= 4'hF;
        we_q     <= 1'b0;
      end else if (grant_d) begin
        last_d_q <= 1'b1;
        addr_q   <= bus.dm_addr;
        wdata_q  <= bus.dm_wdata;
        mask_q   <= bus.dm_mask;
        we_q     <= bus.dm_we;
      end

      if (state_q == BUSY_I) begin
        if (done)     if_rdata_q <= bus.mem_rdata;
        else if (tmo) if_rdata_q <= '0;
      end
      if (state_q == BUSY_D && !we_q) begin
        if (done)     dm_rdata_q <= bus.mem_rdata;
        else if (tmo) dm_rdata_q <= '0;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of address and data buses.
REQ-002 SHALL have parameter Timeout, default 16, max busy cycles awaiting mem_valid (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports if_req, if_addr  input  1, DataWidth  instruction-fetch request and address.
REQ-006 SHALL have ports if_valid, if_stall  output  1 each; if_rdata  output  DataWidth  fetch response.
REQ-007 SHALL have ports dm_req, dm_we  input  1 each; dm_mask  input  4; dm_addr, dm_wdata  input  DataWidth  data-memory request from memory stage.
REQ-008 SHALL have ports dm_valid, dm_stall  output  1 each; dm_rdata  output  DataWidth  data response.
REQ-009 SHALL have ports mem_req, mem_we  output  1 each; mem_mask  output  4; mem_addr, mem_wdata  output  DataWidth  to single-port memory.
REQ-010 SHALL have ports mem_valid  input  1; mem_rdata  input  DataWidth  memory completion.
REQ-011 SHALL have port err  output  1  one-cycle timeout pulse.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE, a request SHALL be granted at the clock edge: only dm_req -> BUSY_D; only if_req -> BUSY_I; both -> requester not granted last (last_grant flag), then update last_grant.
REQ-014 On grant, SHALL register addr, wdata, we, mask of the winner; fetch uses mem_we=0, mem_mask=4'hF; data uses dm_we, dm_mask.
REQ-015 mem_req SHALL be 1 exactly while in BUSY_I/BUSY_D, with mem_* outputs held stable from registered copies.
REQ-016 In BUSY_x with mem_valid=1, SHALL return to IDLE and pulse x_valid for exactly the next cycle.
REQ-017 On fetch completion, SHALL load if_rdata from mem_rdata; on data load (we=0) completion, SHALL load dm_rdata; store completion SHALL leave dm_rdata unchanged.
REQ-018 x_rdata SHALL hold its value until the next completion for that requester.
REQ-019 Minimum latency: req at edge N -> mem_req high from N+1 -> mem_valid at N+1 -> x_valid high during cycle N+2.
REQ-020 x_stall SHALL equal x_req AND NOT x_valid (combinational).
REQ-021 In IDLE the cycle x_valid is high, new grant decision SHALL occur normally (back-to-back allowed); requester must drop or change req in that cycle to avoid re-issue.
REQ-022 mem_valid while IDLE SHALL be ignored.
REQ-023 Deassertion of the owning req during BUSY SHALL not abort; transaction completes and valid pulses.
REQ-024 An 8-bit busy counter SHALL clear on grant and increment each BUSY cycle without mem_valid; on reaching Timeout-1 the FSM SHALL go IDLE, pulse err and x_valid for one cycle, and set x_rdata to 0 (loads/fetch only).
REQ-025 mem_valid in the same cycle as timeout SHALL take priority (normal completion, no err).

Reset
REQ-026 While rst=0, SHALL force state IDLE, last_grant=data (fetch wins first contention), counter 0, and all outputs (mem_*, x_valid, x_rdata, err) to 0; x_stall still follows REQ-020.
REQ-027 Reset asserted mid-transaction SHALL discard it with no valid pulse; after release, pending reqs are re-arbitrated.

Verification
REQ-028 Single fetch: if_req=1, if_addr=0x100, mem_valid 3 cycles after mem_req, mem_rdata=0x00000013 -> mem_req 3 cycles, mem_we=0, mem_mask=F, if_valid 1 cycle, if_rdata=0x13.
REQ-029 Store: dm_req=1, dm_we=1, dm_mask=0011, dm_addr=0x2000, dm_wdata=0xABCD -> mem_* match, dm_valid pulse, dm_rdata unchanged.
REQ-030 Contention: if_req and dm_req both held from reset release, mem_valid immediate -> grants alternate I, D, I, D; no cycle with two valids.
REQ-031 Timeout: dm_req load, mem_valid never -> after Timeout-1 busy cycles err=1 and dm_valid=1 same cycle, dm_rdata=0, FSM IDLE.
REQ-032 Reset mid-op: rst=0 during BUSY_D -> mem_req=0 immediately, no dm_valid; after release with dm_req held, new transaction issued.
REQ-033 Idle noise: mem_valid=1 with no request -> no valid, no err, rdata unchanged.
